// File: rtl/spi_shift_engine.sv
// SPI mode-0 master: fetches {ss_sel, data} from the data buffer and shifts the data out MSB-first.
// Define SPI_RX_CAPTURE_EN to build the MISO receive path (rx_data/rx_valid); otherwise both are tied to 0.
module spi_shift_engine #(
   parameter int CLK_DIV = 4,
   parameter int DATA_W  = 32
) (
   input  logic              SCLK,
   input  logic              ARESETN,
   input  logic              enable,
   output logic              go,
   input  logic              DREADY,
   input  logic [DATA_W+1:0] din,
   output logic              SRESP,
   output logic              spi_sck,
   output logic              spi_mosi,
   input  logic              spi_miso,
   output logic [3:0]        spi_ss_n,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   output logic              busy,
   output logic              done
);

   localparam int CNT_W = $clog2(CLK_DIV + 1);
   localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(CLK_DIV - 1);
   localparam logic [6:0]       LAST_HALF = 7'(2 * DATA_W - 1);
   localparam logic [6:0]       LAST_FALL = 7'(2 * DATA_W - 2);

   typedef enum logic [2:0] {
      IDLE,
      WAIT_DATA,
      SS_SETUP,
      SHIFT,
      SS_HOLD,
      DONE
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  divCnt_q, divCnt_d;
   logic [6:0]        edgeCnt_q, edgeCnt_d;
   logic [DATA_W-1:0] txShift_q, txShift_d;
   logic [1:0]        ssSel_q, ssSel_d;
   logic              sck_q, sck_d;
   logic              go_q, go_d;
   logic              halfEnd;
   logic              sampleRise;
   logic [3:0]        ssDecode;

   assign halfEnd = (divCnt_q == DIV_LAST);

   // Next-state logic; edgeCnt_q counts completed half-periods within SHIFT
   always_comb begin
      state_d    = state_q;
      divCnt_d   = '0;
      edgeCnt_d  = edgeCnt_q;
      txShift_d  = txShift_q;
      ssSel_d    = ssSel_q;
      sck_d      = 1'b0;
      go_d       = 1'b0;
      sampleRise = 1'b0;
      case (state_q)
         IDLE: begin
            edgeCnt_d = '0;
            if (enable) begin
               go_d    = 1'b1;
               state_d = WAIT_DATA;
            end
         end
         WAIT_DATA: begin
            if (DREADY) begin
               txShift_d = din[DATA_W-1:0];
               ssSel_d   = din[DATA_W+1:DATA_W];
               state_d   = SS_SETUP;
            end
         end
         SS_SETUP: begin
            divCnt_d = divCnt_q + 1'b1;
            if (halfEnd) begin
               divCnt_d   = '0;
               edgeCnt_d  = '0;
               sck_d      = 1'b1;
               sampleRise = 1'b1;
               state_d    = SHIFT;
            end
         end
         SHIFT: begin
            sck_d    = sck_q;
            divCnt_d = divCnt_q + 1'b1;
            if (halfEnd) begin
               divCnt_d  = '0;
               edgeCnt_d = edgeCnt_q + 7'd1;
               if (edgeCnt_q == LAST_HALF) begin
                  sck_d   = 1'b0;
                  state_d = SS_HOLD;
               end else begin
                  sck_d = ~sck_q;
                  // The final falling edge leaves bit 0 on MOSI through the hold phase
                  if (sck_q) begin
                     if (edgeCnt_q != LAST_FALL) begin
                        txShift_d = {txShift_q[DATA_W-2:0], 1'b0};
                     end
                  end else begin
                     sampleRise = 1'b1;
                  end
               end
            end
         end
         SS_HOLD: begin
            divCnt_d = divCnt_q + 1'b1;
            if (halfEnd) begin
               divCnt_d = '0;
               state_d  = DONE;
            end
         end
         DONE: begin
            edgeCnt_d = '0;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge SCLK) begin
      if (!ARESETN) begin
         state_q   <= IDLE;
         divCnt_q  <= '0;
         edgeCnt_q <= '0;
         txShift_q <= '0;
         ssSel_q   <= '0;
         sck_q     <= 1'b0;
         go_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         divCnt_q  <= divCnt_d;
         edgeCnt_q <= edgeCnt_d;
         txShift_q <= txShift_d;
         ssSel_q   <= ssSel_d;
         sck_q     <= sck_d;
         go_q      <= go_d;
      end
   end

   assign ssDecode = 4'b0001 << ssSel_q;

   // Chip select and MOSI are only driven between setup and hold; everything else is idle-level
   always_comb begin
      spi_ss_n = 4'hF;
      spi_mosi = 1'b0;
      if (state_q == SS_SETUP || state_q == SHIFT || state_q == SS_HOLD) begin
         spi_ss_n = ~ssDecode;
         spi_mosi = txShift_q[DATA_W-1];
      end
   end

   assign go      = go_q;
   assign SRESP   = (state_q == WAIT_DATA) && DREADY;
   assign spi_sck = sck_q;
   assign busy    = (state_q != IDLE);
   assign done    = (state_q == DONE);

`ifdef SPI_RX_CAPTURE_EN
   logic [DATA_W-1:0] rxShift_q, rxShift_d;
   logic [DATA_W-1:0] rxData_q, rxData_d;

   always_comb begin
      rxShift_d = rxShift_q;
      rxData_d  = rxData_q;
      if (sampleRise) begin
         rxShift_d = {rxShift_q[DATA_W-2:0], spi_miso};
      end
      if (state_q == SS_HOLD && halfEnd) begin
         rxData_d = rxShift_q;
      end
   end

   always_ff @(posedge SCLK) begin
      if (!ARESETN) begin
         rxShift_q <= '0;
         rxData_q  <= '0;
      end else begin
         rxShift_q <= rxShift_d;
         rxData_q  <= rxData_d;
      end
   end

   assign rx_data  = rxData_q;
   assign rx_valid = (state_q == DONE);
`else
   logic unusedRx;
   assign unusedRx = spi_miso ^ sampleRise;
   assign rx_data  = '0;
   assign rx_valid = 1'b0;
`endif

endmodule

// File: tb/tb_spi_shift_engine.sv
// Directed self-checking bench for spi_shift_engine (CLK_DIV=4, DATA_W=32).
// Each test task drives its scenario through run_frame and compares the recorded observations inline.
module tb_spi_shift_engine;

   localparam int CLK_DIV = 4;
   localparam int FRAME_LAT = 1 + CLK_DIV + 64 * CLK_DIV + CLK_DIV;

   logic        SCLK;
   logic        ARESETN;
   logic        enable;
   logic        go;
   logic        DREADY;
   logic [33:0] din;
   logic        SRESP;
   logic        spi_sck;
   logic        spi_mosi;
   logic        spi_miso;
   logic [3:0]  spi_ss_n;
   logic [31:0] rx_data;
   logic        rx_valid;
   logic        busy;
   logic        done;

   logic misoLoop;
   logic misoTog;

   int errors;
   int checks;

   int          goCount, goCycle, srespCount, srespCycle, ssCycle, rises, mosiGlitch;
   int          doneCycle, rxValidCount, rxNonZero, onesBefore;
   logic [3:0]  ssVal, ssAfter;
   logic [31:0] mosiWord, rxAtDone;
   logic        rxValidAtDone, sckAfter, doneAfter, rxvAfter, busyAfter;
   bit          timedOut, abortHit;

   assign spi_miso = misoLoop ? spi_mosi : misoTog;

   spi_shift_engine #(.CLK_DIV(CLK_DIV), .DATA_W(32)) dut (
      .SCLK     (SCLK),
      .ARESETN  (ARESETN),
      .enable   (enable),
      .go       (go),
      .DREADY   (DREADY),
      .din      (din),
      .SRESP    (SRESP),
      .spi_sck  (spi_sck),
      .spi_mosi (spi_mosi),
      .spi_miso (spi_miso),
      .spi_ss_n (spi_ss_n),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .busy     (busy),
      .done     (done)
   );

   initial SCLK = 1'b0;
   always #5 SCLK = ~SCLK;

   // Inputs change 1 unit after a rising edge; outputs are sampled on the falling edge
   task automatic run_frame(input logic [33:0] word, input int dly, input int abortRises, input bit dropEnable);
      int   cyc, waitCnt, abortWait;
      bit   haveGo, driven, pendingReset, abortArmed;
      logic nextDready, prevSck, prevMosi;
      goCount = 0; goCycle = -1; srespCount = 0; srespCycle = -1; ssCycle = -1; rises = 0;
      mosiGlitch = 0; doneCycle = -1; rxValidCount = 0; rxNonZero = 0; onesBefore = 0;
      ssVal = 4'hF; mosiWord = '0; rxAtDone = '0; rxValidAtDone = 1'b0;
      ssAfter = 4'h0; sckAfter = 1'bx; doneAfter = 1'bx; rxvAfter = 1'bx; busyAfter = 1'bx;
      timedOut = 0; abortHit = 0;
      cyc = 0; waitCnt = 0; abortWait = 0;
      haveGo = 0; driven = 0; pendingReset = 0; abortArmed = 0;
      nextDready = 1'b0; prevSck = spi_sck; prevMosi = spi_mosi;
      while (1) begin
         @(posedge SCLK); #1;
         DREADY = nextDready;
         if (nextDready) din = word;
         misoTog = ~misoTog;
         if (pendingReset) ARESETN = 1'b0;
         @(negedge SCLK);
         cyc++;
         if (go) begin
            goCount++;
            if (!haveGo) begin
               haveGo  = 1;
               goCycle = cyc;
               if (dropEnable) enable = 1'b0;
            end
         end
         if (SRESP) begin
            srespCount++;
            if (srespCycle < 0) srespCycle = cyc;
            nextDready = 1'b0;
         end else if (haveGo && !driven) begin
            if (waitCnt == dly) begin
               nextDready = 1'b1;
               driven     = 1;
            end else begin
               waitCnt++;
            end
         end
         if (spi_ss_n != 4'hF) begin
            if (ssCycle < 0) begin
               ssCycle = cyc;
               ssVal   = spi_ss_n;
            end
         end else if (ssCycle < 0) begin
            onesBefore++;
         end
         if (spi_sck && !prevSck) begin
            rises++;
            mosiWord = {mosiWord[30:0], spi_mosi};
         end
         if (spi_sck && spi_mosi !== prevMosi) mosiGlitch++;
         if (rx_valid) rxValidCount++;
         if (rx_data !== 32'h0) rxNonZero++;
         prevSck  = spi_sck;
         prevMosi = spi_mosi;
         if (abortArmed) begin
            abortWait--;
            if (abortWait == 0) begin
               abortHit  = 1;
               ssAfter   = spi_ss_n;
               sckAfter  = spi_sck;
               doneAfter = done;
               rxvAfter  = rx_valid;
               busyAfter = busy;
               break;
            end
         end else if (abortRises > 0 && rises == abortRises) begin
            pendingReset = 1;
            abortArmed   = 1;
            abortWait    = 2;
         end
         if (done) begin
            doneCycle     = cyc;
            rxAtDone      = rx_data;
            rxValidAtDone = rx_valid;
            break;
         end
         if (cyc > 2000) begin
            timedOut = 1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      ARESETN = 1'b0; enable = 1'b0; DREADY = 1'b0; din = '0; misoLoop = 1'b0; misoTog = 1'b0;
      repeat (3) @(posedge SCLK);
      @(negedge SCLK);
      checks++; if (spi_ss_n !== 4'hF) begin errors++; $display("[TB] FAIL reset_ss_n: got %h expected f", spi_ss_n); end
      checks++; if (spi_sck !== 1'b0) begin errors++; $display("[TB] FAIL reset_sck: got %b expected 0", spi_sck); end
      checks++; if (spi_mosi !== 1'b0) begin errors++; $display("[TB] FAIL reset_mosi: got %b expected 0", spi_mosi); end
      checks++; if (go !== 1'b0) begin errors++; $display("[TB] FAIL reset_go: got %b expected 0", go); end
      checks++; if (SRESP !== 1'b0) begin errors++; $display("[TB] FAIL reset_sresp: got %b expected 0", SRESP); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (rx_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rx_valid: got %b expected 0", rx_valid); end
      checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
      checks++; if (rx_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_rx_data: got %h expected 0", rx_data); end
      @(posedge SCLK); #1;
      ARESETN = 1'b1;
      @(negedge SCLK);
   endtask

   task automatic test_single_frame();
      misoLoop = 1'b1;
      enable   = 1'b1;
      run_frame({2'd2, 32'hA5A5_0F0F}, 0, 0, 1);
      checks++; if (timedOut) begin errors++; $display("[TB] FAIL single_timeout: got no done expected done"); end
      checks++; if (goCount !== 1) begin errors++; $display("[TB] FAIL single_go_count: got %0d expected 1", goCount); end
      checks++; if (ssVal !== 4'b1011) begin errors++; $display("[TB] FAIL single_ss_n: got %b expected 1011", ssVal); end
      checks++; if (rises !== 32) begin errors++; $display("[TB] FAIL single_rises: got %0d expected 32", rises); end
      checks++; if (mosiWord !== 32'hA5A5_0F0F) begin errors++; $display("[TB] FAIL single_mosi: got %h expected a5a50f0f", mosiWord); end
      checks++; if (mosiGlitch !== 0) begin errors++; $display("[TB] FAIL single_mosi_stable: got %0d changes expected 0", mosiGlitch); end
      checks++; if (doneCycle - srespCycle !== FRAME_LAT) begin errors++; $display("[TB] FAIL single_latency: got %0d expected %0d", doneCycle - srespCycle, FRAME_LAT); end
`ifdef SPI_RX_CAPTURE_EN
      checks++; if (rxAtDone !== 32'hA5A5_0F0F) begin errors++; $display("[TB] FAIL single_rx_data: got %h expected a5a50f0f", rxAtDone); end
      checks++; if (rxValidAtDone !== 1'b1) begin errors++; $display("[TB] FAIL single_rx_valid: got %b expected 1", rxValidAtDone); end
`else
      checks++; if (rxAtDone !== 32'h0) begin errors++; $display("[TB] FAIL single_rx_data: got %h expected 0", rxAtDone); end
      checks++; if (rxValidAtDone !== 1'b0) begin errors++; $display("[TB] FAIL single_rx_valid: got %b expected 0", rxValidAtDone); end
`endif
      repeat (3) @(negedge SCLK);
   endtask

   task automatic test_handshake_latency();
      misoLoop = 1'b1;
      enable   = 1'b1;
      run_frame({2'd1, 32'h0000_0001}, 10, 0, 1);
      checks++; if (timedOut) begin errors++; $display("[TB] FAIL hs_timeout: got no done expected done"); end
      checks++; if (goCount !== 1) begin errors++; $display("[TB] FAIL hs_go_count: got %0d expected 1", goCount); end
      checks++; if (srespCount !== 1) begin errors++; $display("[TB] FAIL hs_sresp_count: got %0d expected 1", srespCount); end
      checks++; if (srespCycle - goCycle !== 11) begin errors++; $display("[TB] FAIL hs_sresp_delay: got %0d expected 11", srespCycle - goCycle); end
      checks++; if (ssCycle - srespCycle !== 1) begin errors++; $display("[TB] FAIL hs_ss_start: got %0d expected 1", ssCycle - srespCycle); end
      checks++; if (ssVal !== 4'b1101) begin errors++; $display("[TB] FAIL hs_ss_n: got %b expected 1101", ssVal); end
      repeat (3) @(negedge SCLK);
   endtask

   task automatic test_back_to_back();
      logic [33:0] words [3];
      logic [3:0]  expSs [3];
      int          doneSeen;
      words[0] = {2'd0, 32'h1234_5678}; expSs[0] = 4'b1110;
      words[1] = {2'd1, 32'h8000_0001}; expSs[1] = 4'b1101;
      words[2] = {2'd3, 32'hFFFF_0000}; expSs[2] = 4'b0111;
      doneSeen = 0;
      misoLoop = 1'b1;
      enable   = 1'b1;
      for (int f = 0; f < 3; f++) begin
         run_frame(words[f], 0, 0, (f == 2));
         if (doneCycle >= 0) doneSeen++;
         checks++; if (ssVal !== expSs[f]) begin errors++; $display("[TB] FAIL b2b_ss_n%0d: got %b expected %b", f, ssVal, expSs[f]); end
         checks++; if (mosiWord !== words[f][31:0]) begin errors++; $display("[TB] FAIL b2b_mosi%0d: got %h expected %h", f, mosiWord, words[f][31:0]); end
         if (f > 0) begin
            checks++; if (onesBefore + 1 < 2) begin errors++; $display("[TB] FAIL b2b_gap%0d: got %0d idle cycles expected at least 2", f, onesBefore + 1); end
         end
      end
      checks++; if (doneSeen !== 3) begin errors++; $display("[TB] FAIL b2b_done_count: got %0d expected 3", doneSeen); end
      repeat (3) @(negedge SCLK);
   endtask

   task automatic test_reset_mid_shift();
      int lateDone, lateRxv, lateSs;
      misoLoop = 1'b1;
      enable   = 1'b1;
      run_frame({2'd1, 32'hDEAD_BEEF}, 0, 16, 1);
      checks++; if (!abortHit) begin errors++; $display("[TB] FAIL mid_abort_reached: got 0 expected 1"); end
      checks++; if (ssAfter !== 4'hF) begin errors++; $display("[TB] FAIL mid_ss_n: got %h expected f", ssAfter); end
      checks++; if (sckAfter !== 1'b0) begin errors++; $display("[TB] FAIL mid_sck: got %b expected 0", sckAfter); end
      checks++; if (busyAfter !== 1'b0) begin errors++; $display("[TB] FAIL mid_busy: got %b expected 0", busyAfter); end
      checks++; if (doneAfter !== 1'b0 || rxvAfter !== 1'b0) begin errors++; $display("[TB] FAIL mid_done_rxv: got %b%b expected 00", doneAfter, rxvAfter); end
      repeat (2) @(posedge SCLK);
      #1 ARESETN = 1'b1;
      lateDone = 0; lateRxv = 0; lateSs = 0;
      repeat (300) begin
         @(negedge SCLK);
         if (done) lateDone++;
         if (rx_valid) lateRxv++;
         if (spi_ss_n !== 4'hF) lateSs++;
      end
      checks++; if (lateDone !== 0) begin errors++; $display("[TB] FAIL mid_late_done: got %0d expected 0", lateDone); end
      checks++; if (lateRxv !== 0) begin errors++; $display("[TB] FAIL mid_late_rx_valid: got %0d expected 0", lateRxv); end
      checks++; if (lateSs !== 0) begin errors++; $display("[TB] FAIL mid_late_ss: got %0d asserted cycles expected 0", lateSs); end
   endtask

   task automatic test_capture_option();
      misoLoop = 1'b0;
      enable   = 1'b1;
      run_frame({2'd3, 32'h0F0F_F0F0}, 2, 0, 1);
      checks++; if (doneCycle < 0) begin errors++; $display("[TB] FAIL cap_done: got no done expected done"); end
`ifdef SPI_RX_CAPTURE_EN
      checks++; if (rxValidCount !== 1) begin errors++; $display("[TB] FAIL cap_rx_valid_count: got %0d expected 1", rxValidCount); end
`else
      checks++; if (rxValidCount !== 0) begin errors++; $display("[TB] FAIL cap_rx_valid_count: got %0d expected 0", rxValidCount); end
      checks++; if (rxNonZero !== 0) begin errors++; $display("[TB] FAIL cap_rx_data_zero: got %0d nonzero cycles expected 0", rxNonZero); end
`endif
      repeat (3) @(negedge SCLK);
   endtask

   initial begin
      errors = 0;
      checks = 0;
      test_reset();
      test_single_frame();
      test_handshake_latency();
      test_back_to_back();
      test_reset_mid_shift();
      test_capture_option();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
